// File: rtl/jrt_run_driver.sv
`default_nettype none
// ============================================================================
// Module      : jrt_run_driver
// Description : Caller-side sequencer for a JRT single-method run interface.
//               Buffers host operands in a FIFO, issues one run request per
//               operand, follows the callee busy flag (with rise and run
//               timeouts) and hands each 32-bit result back to the host.
// Revision    : 1.0 - initial release
// ============================================================================
module jrt_run_driver #(
    parameter int DEPTH     = 4,
    parameter int RISE_WAIT = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic [31:0] i_op_data,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [31:0] o_res_data,
    output logic        o_res_timeout,
    output logic        o_run_req,
    output logic [31:0] o_run_input_a_0,
    input  logic        i_run_busy,
    input  logic [31:0] i_run_return,
    output logic        o_idle,
    output logic [15:0] o_done_count
);

    localparam int          c_addr_w    = $clog2(DEPTH);
    localparam logic [15:0] c_rise_wait = 16'(RISE_WAIT);
    localparam logic [15:0] c_timeout   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RISE = 3'd2,
        S_BUSY = 3'd3,
        S_EMIT = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Operand FIFO storage and pointers (extra MSB separates full/empty)
    // ------------------------------------------------------------------
    logic [31:0]       r_fifo_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;

    state_t            r_state;
    logic [15:0]       r_wait_cnt;
    logic              r_run_req;
    logic [31:0]       r_run_input;
    logic              r_res_valid;
    logic [31:0]       r_res_data;
    logic              r_res_timeout;
    logic [15:0]       r_done_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [15:0]       w_cnt_inc;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                       (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    // Ready looks only at the full flag: a pop in the same cycle does not
    // make room for a push that cycle.
    assign w_push    = ce && i_op_valid && !w_full;
    // A new run starts only once any previous callee activity has ended.
    assign w_pop     = ce && (r_state == S_IDLE) && !w_empty && !i_run_busy;
    assign w_cnt_inc = r_wait_cnt + 16'd1;

    // Operand storage write; contents need no reset because pointers gate use
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[c_addr_w-1:0]] <= i_op_data;
        end
    end

    // FIFO pointer update; reset flushes any queued operands
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Run sequencer: request, wait for busy rise, wait for busy fall, emit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_run_req     <= 1'b0;
            r_run_input   <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
            r_done_count  <= '0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_run_input <= r_fifo_mem[r_rd_ptr[c_addr_w-1:0]];
                        r_run_req   <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_run_req  <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= S_RISE;
                end
                S_RISE: begin
                    if (i_run_busy) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_BUSY;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_rise_wait) begin
                            r_res_data    <= '0;
                            r_res_timeout <= 1'b1;
                            r_res_valid   <= 1'b1;
                            r_state       <= S_EMIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (!i_run_busy) begin
                        r_res_data    <= i_run_return;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_EMIT;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_timeout) begin
                            r_res_data    <= '0;
                            r_res_timeout <= 1'b1;
                            r_res_valid   <= 1'b1;
                            r_state       <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_res_ready) begin
                        r_res_valid  <= 1'b0;
                        r_done_count <= r_done_count + 16'd1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_run_req   <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_op_ready      = !w_full;
    assign o_res_valid     = r_res_valid;
    assign o_res_data      = r_res_data;
    assign o_res_timeout   = r_res_timeout;
    assign o_run_req       = r_run_req;
    assign o_run_input_a_0 = r_run_input;
    assign o_idle          = (r_state == S_IDLE) && w_empty;
    assign o_done_count    = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_jrt_run_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jrt_run_driver
// Description : Directed self-checking bench for jrt_run_driver with a
//               behavioural JRT callee model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jrt_run_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        i_op_valid = 1'b0;
    logic        o_op_ready;
    logic [31:0] i_op_data = '0;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic [31:0] o_res_data;
    logic        o_res_timeout;
    logic        o_run_req;
    logic [31:0] o_run_input_a_0;
    logic        i_run_busy;
    logic [31:0] i_run_return;
    logic        o_idle;
    logic [15:0] o_done_count;

    int n_chk = 0;
    int n_err = 0;

    // Bench controls
    bit ce_tog = 1'b0;
    bit ce_edge = 1'b1;
    bit force_busy = 1'b0;
    bit cb_never = 1'b0;
    int cb_len = 35;

    // Callee model state
    logic        cb_busy = 1'b0;
    int          cb_rem = 0;
    logic [31:0] cb_ret = '0;

    // Monitors
    int          req_cnt = 0;
    int          req_raw = 0;
    int          res_wr = 0;
    logic [31:0] res_mem [64];
    logic        res_to  [64];

    jrt_run_driver #(.DEPTH(4), .RISE_WAIT(4), .TIMEOUT(255)) dut (
        .clock          (clock),
        .reset          (reset),
        .ce             (ce),
        .i_op_valid     (i_op_valid),
        .o_op_ready     (o_op_ready),
        .i_op_data      (i_op_data),
        .o_res_valid    (o_res_valid),
        .i_res_ready    (i_res_ready),
        .o_res_data     (o_res_data),
        .o_res_timeout  (o_res_timeout),
        .o_run_req      (o_run_req),
        .o_run_input_a_0(o_run_input_a_0),
        .i_run_busy     (i_run_busy),
        .i_run_return   (i_run_return),
        .o_idle         (o_idle),
        .o_done_count   (o_done_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] exp_ret(input logic [31:0] op);
        if (op == 32'h4040_0000) return 32'h4012_6F6F;
        return op ^ 32'hDEAD_BEEF;
    endfunction

    assign i_run_busy   = cb_busy | force_busy;
    assign i_run_return = cb_ret;

    // Callee: busy from the edge that samples the request for cb_len edges
    always @(posedge clock) begin
        if (ce) begin
            if (cb_busy) begin
                if (cb_rem <= 1) cb_busy <= 1'b0;
                cb_rem <= cb_rem - 1;
            end else if (o_run_req && !cb_never) begin
                cb_busy <= 1'b1;
                cb_rem  <= cb_len;
                cb_ret  <= exp_ret(o_run_input_a_0);
            end
        end
    end

    // Request and result monitors
    always @(posedge clock) begin
        if (!reset) begin
            if (o_run_req) req_raw <= req_raw + 1;
            if (o_run_req && ce) req_cnt <= req_cnt + 1;
            if (ce && o_res_valid && i_res_ready && res_wr < 64) begin
                res_mem[res_wr] <= o_res_data;
                res_to[res_wr]  <= o_res_timeout;
                res_wr          <= res_wr + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        ce_edge = ce;
        @(posedge clock);
        #1;
        if (ce_tog) ce = ~ce;
    endtask

    task automatic do_reset();
        ce_tog = 1'b0;
        ce = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        int w;
        i_op_valid = 1'b1;
        i_op_data  = d;
        w = 0;
        while (!(o_op_ready && ce) && w < 500) begin
            tick();
            w++;
        end
        if (w >= 500) chk("push_wait", 32'd1, 32'd0);
        tick();
        i_op_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n, output int n_eff);
        n = 0;
        n_eff = 0;
        while (!o_res_valid && n < 1000) begin
            tick();
            n++;
            if (ce_edge) n_eff++;
        end
    endtask

    task automatic accept();
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
    endtask

    task automatic wait_busy_low();
        int w;
        w = 0;
        while (i_run_busy && w < 400) begin
            tick();
            w++;
        end
        if (w >= 400) chk("busy_low_wait", 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ne, base, rbase, rawbase, bad;
        logic [31:0] ops [5];
        logic [31:0] held;
        ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000; ops[2] = 32'h4040_0000;
        ops[3] = 32'h4080_0000; ops[4] = 32'h40A0_0000;

        // ---------------- reset values
        do_reset();
        chk("rst_op_ready", {31'd0, o_op_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
        chk("rst_res_data", o_res_data, 32'd0);
        chk("rst_res_timeout", {31'd0, o_res_timeout}, 32'd0);
        chk("rst_run_req", {31'd0, o_run_req}, 32'd0);
        chk("rst_run_input", o_run_input_a_0, 32'd0);
        chk("rst_idle", {31'd0, o_idle}, 32'd1);
        chk("rst_done_count", {16'd0, o_done_count}, 32'd0);

        // ---------------- single divide run
        cb_len = 35;
        rbase = req_cnt;
        push(32'h4040_0000);
        wait_valid(n, ne);
        chk("t1_latency", n, 32'd38);
        chk("t1_req_pulses", req_cnt - rbase, 32'd1);
        chk("t1_run_input", o_run_input_a_0, 32'h4040_0000);
        chk("t1_res_data", o_res_data, 32'h4012_6F6F);
        chk("t1_res_timeout", {31'd0, o_res_timeout}, 32'd0);
        accept();
        chk("t1_done_count", {16'd0, o_done_count}, 32'd1);
        chk("t1_valid_drop", {31'd0, o_res_valid}, 32'd0);
        chk("t1_idle", {31'd0, o_idle}, 32'd1);

        // ---------------- five operands through a 4-deep FIFO
        do_reset();
        base = res_wr;
        force_busy = 1'b1;
        i_res_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(ops[i]);
        chk("t2_full_ready", {31'd0, o_op_ready}, 32'd0);
        chk("t2_full_idle", {31'd0, o_idle}, 32'd0);
        chk("t2_no_req_busy", {31'd0, o_run_req}, 32'd0);
        i_op_valid = 1'b1;
        i_op_data  = ops[4];
        tick(); tick(); tick();
        chk("t2_5th_waits", {31'd0, o_op_ready}, 32'd0);
        force_busy = 1'b0;
        push(ops[4]);
        n = 0;
        while ((res_wr - base) < 5 && n < 2000) begin
            tick();
            n++;
        end
        i_res_ready = 1'b0;
        chk("t2_result_count", res_wr - base, 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_res_data%0d", i), res_mem[base + i], exp_ret(ops[i]));
            chk($sformatf("t2_res_to%0d", i), {31'd0, res_to[base + i]}, 32'd0);
        end
        chk("t2_done_count", {16'd0, o_done_count}, 32'd5);

        // ---------------- callee never raises busy
        do_reset();
        cb_never = 1'b1;
        push(32'h1234_5678);
        wait_valid(n, ne);
        chk("t3_latency", n, 32'd6);
        chk("t3_res_timeout", {31'd0, o_res_timeout}, 32'd1);
        chk("t3_res_data", o_res_data, 32'd0);
        accept();
        chk("t3_done_count", {16'd0, o_done_count}, 32'd1);
        cb_never = 1'b0;

        // ---------------- callee busy 300 cycles: run timeout
        do_reset();
        cb_len = 300;
        push(32'h0000_0001);
        wait_valid(n, ne);
        chk("t4_latency", n, 32'd258);
        chk("t4_res_timeout", {31'd0, o_res_timeout}, 32'd1);
        chk("t4_res_data", o_res_data, 32'd0);
        i_res_ready = 1'b1;
        push(32'h0000_0002);
        i_res_ready = 1'b0;
        rbase = req_cnt;
        wait_busy_low();
        chk("t4_no_req_while_busy", req_cnt - rbase, 32'd0);
        chk("t4_req_low_at_drop", {31'd0, o_run_req}, 32'd0);
        cb_len = 35;
        tick();
        chk("t4_req_after_drop", {31'd0, o_run_req}, 32'd1);
        chk("t4_run_input2", o_run_input_a_0, 32'h0000_0002);
        wait_valid(n, ne);
        chk("t4_res2_data", o_res_data, exp_ret(32'h0000_0002));
        chk("t4_res2_timeout", {31'd0, o_res_timeout}, 32'd0);
        accept();
        chk("t4_done_count", {16'd0, o_done_count}, 32'd2);

        // ---------------- ce toggling, held result in EMIT
        do_reset();
        rbase = req_cnt;
        rawbase = req_raw;
        push(32'h4040_0000);
        ce_tog = 1'b1;
        ce = 1'b0;
        wait_valid(n, ne);
        chk("t5_latency_total", n, 32'd76);
        chk("t5_latency_ce", ne, 32'd38);
        chk("t5_req_raw", req_raw - rawbase, 32'd2);
        chk("t5_req_eff", req_cnt - rbase, 32'd1);
        held = o_res_data;
        chk("t5_res_data", held, 32'h4012_6F6F);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!o_res_valid || o_res_data !== held) bad++;
        end
        chk("t5_hold_stable", bad, 32'd0);
        chk("t5_no_second_req", req_cnt - rbase, 32'd1);
        i_res_ready = 1'b1;
        tick();
        tick();
        i_res_ready = 1'b0;
        chk("t5_done_count", {16'd0, o_done_count}, 32'd1);
        chk("t5_valid_drop", {31'd0, o_res_valid}, 32'd0);
        ce_tog = 1'b0;
        ce = 1'b1;

        // ---------------- reset during BUSY with two queued
        do_reset();
        cb_len = 35;
        push(32'h0000_00B1);
        push(32'h0000_00B2);
        push(32'h0000_00B3);
        for (int i = 0; i < 10; i++) tick();
        chk("t6_busy_not_idle", {31'd0, o_idle}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_idle", {31'd0, o_idle}, 32'd1);
        chk("t6_op_ready", {31'd0, o_op_ready}, 32'd1);
        chk("t6_done_count", {16'd0, o_done_count}, 32'd0);
        chk("t6_res_valid", {31'd0, o_res_valid}, 32'd0);
        chk("t6_run_input", o_run_input_a_0, 32'd0);
        chk("t6_run_req", {31'd0, o_run_req}, 32'd0);
        rbase = req_cnt;
        push(32'h0000_00B4);
        wait_busy_low();
        chk("t6_blocked_by_busy", req_cnt - rbase, 32'd0);
        wait_valid(n, ne);
        chk("t6_res_data", o_res_data, exp_ret(32'h0000_00B4));
        accept();
        for (int i = 0; i < 5; i++) tick();
        chk("t6_flushed_done", {16'd0, o_done_count}, 32'd1);
        chk("t6_flushed_idle", {31'd0, o_idle}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jrt_run_driver.md
# jrt_run_driver

Caller-side sequencer for the single-method run interface exposed by the generated JRT compute modules (`i_run_req` / `o_run_busy` / `o_run_return` / `i_run_input_a_0`). It accepts 32-bit operands from a host over a valid/ready stream and buffers them in a small FIFO. For each operand it issues one run request to the attached callee (e.g. the float-divide JRT block), tracks the callee's busy flag to completion, and returns the 32-bit result on a valid/ready stream. The block sits between host/bus glue and one JRT method instance and shares that instance's `clock` and `ce`.

## Interface
- `DEPTH`, 4 — operand FIFO entries; power of two, at least 2.
- `RISE_WAIT`, 4 — `ce` cycles allowed between the request and busy rising.
- `TIMEOUT`, 255 — `ce` cycles allowed with busy high; must exceed the callee's run length.
- `clock` in 1 — sole clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `ce` in 1 — clock enable; every register updates only when `ce`=1. Tie to the callee's `ce`.
- `i_op_valid` in 1 — host operand valid.
- `o_op_ready` out 1 — FIFO not full.
- `i_op_data` in 32 — operand.
- `o_res_valid` out 1 — result valid.
- `i_res_ready` in 1 — host accepts result.
- `o_res_data` out 32 — callee return value, or 0 on timeout.
- `o_res_timeout` out 1 — result was produced by a timeout.
- `o_run_req` out 1 — to callee `i_run_req`.
- `o_run_input_a_0` out 32 — to callee `i_run_input_a_0`.
- `i_run_busy` in 1 — from callee `o_run_busy`.
- `i_run_return` in 32 — from callee `o_run_return`.
- `o_idle` out 1 — FSM in IDLE and FIFO empty.
- `o_done_count` out 16 — results handed off; wraps at 0xFFFF→0.

## Operation
- Reset values: `o_op_ready`=1, `o_res_valid`=0, `o_res_data`=0, `o_res_timeout`=0, `o_run_req`=0, `o_run_input_a_0`=0, `o_idle`=1, `o_done_count`=0. FIFO is empty and FSM is in IDLE.
- FIFO push: on `i_op_valid & o_op_ready & ce`. `o_op_ready` = !full and depends only on the full flag, so a push while full is refused even if a pop happens in the same cycle. Push and pop in the same cycle are allowed when not full. Pointers wrap modulo `DEPTH`.
- IDLE: if FIFO is non-empty and `i_run_busy`=0, go to REQ. In that same edge, pop the head into `o_run_input_a_0` and set `o_run_req`=1.
- REQ (lasts exactly one `ce` cycle): clear `o_run_req`, reset the wait counter, go to RISE.
- RISE: if `i_run_busy`=1, go to BUSY and clear the counter. Otherwise increment the counter; when it reaches `RISE_WAIT`, go to EMIT with timeout=1 and data=0.
- BUSY: if `i_run_busy`=0, capture `i_run_return` into `o_res_data` with timeout=0 and go to EMIT. Otherwise increment the counter; when it reaches `TIMEOUT`, go to EMIT with timeout=1 and data=0. After a timeout the next request is still gated by `i_run_busy`=0 in IDLE.
- EMIT: hold `o_res_valid`=1 with data and timeout stable until `i_res_ready`=1. On handshake, drop valid, increment `o_done_count`, return to IDLE.
- `o_run_input_a_0` holds its value after the request; it changes only on a pop.

## Timing
- `o_run_req` is registered. The callee samples it at the edge following assertion (edge E0), and busy is seen high from E0.
- With the float-divide callee, busy stays high for 35 cycles (E0..E35). The callee's return is valid from E35, and busy reads 0 after E35.
- Result latency, operand-at-FIFO-head to `o_res_valid`: 1 (IDLE→REQ) + 1 (REQ) + 35 busy cycles + 1 capture ≈ 38 `ce` cycles.
- Back-to-back operands: the next request issues 1 cycle after the EMIT handshake at the earliest. There is no overlap; one run is outstanding at a time.
- `ce`=0 freezes all state, counters and outputs, including a held `o_run_req`.
- Reset mid-run: FIFO is flushed, FSM goes to IDLE, all outputs take their reset values. Any callee still busy blocks new requests until its busy drops.

## Test plan
- Reset with `ce`=1, then push 0x40400000 (3.0). Callee model sets busy for 35 cycles and returns 0x40126F6F. Expect `o_run_req` high for exactly 1 cycle, `o_run_input_a_0`=0x40400000, `o_res_data`=0x40126F6F, `o_res_timeout`=0, `o_done_count`=1.
- Push 5 operands back-to-back with `DEPTH`=4. Expect the 5th push to wait on `o_op_ready`=0, all 5 results in order, and `o_done_count`=5.
- Callee never raises busy. Expect the result after `RISE_WAIT` cycles with `o_res_timeout`=1 and `o_res_data`=0.
- Callee holds busy for 300 cycles. Expect a timeout result at 255 cycles, and no new `o_run_req` until busy drops.
- Hold `i_res_ready`=0 for 20 cycles in EMIT, with `ce` toggling 1/0 throughout. Expect data stable and no second request; a stall at `ce`=0 extends latency 1:1.
- Assert `reset` while in BUSY with 2 operands queued. Expect the FIFO empty, `o_idle`=1, and `o_done_count`=0 the next cycle.
